button_encoder: RTL and testbench

Input front end for the game controller: samples four raw, asynchronous, active-high player buttons, synchronizes and debounces them, and encodes each accepted press as a 2-bit colour code with a one-cycle `IN_VALID` strobe. Its `IN`/`IN_VALID` outputs drive the controller's input port directly, so the controller sees only clean, single, already-encoded presses. The block also rejects chord presses (two or more buttons at once) and requires a debounced full release before it accepts the next press.

---
 rtl/button_encoder_if.sv | 28 ++
 rtl/button_encoder.sv | 151 +++++++++++++++
 tb/tb_button_encoder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/button_encoder_if.sv
// Player-button front-end bundle: raw buttons and enable in, encoded press out.
// Combinational bundle only; adds no latency.
// No backpressure: IN/IN_VALID is a fire-and-forget strobe.
interface button_encoder_if;
  logic [3:0] BTN;
  logic       ENABLE;
  logic [1:0] IN;
  logic       IN_VALID;
  logic       PRESSED;

  // Master drives buttons/enable and consumes the encoded press.
  modport master (
    output BTN,
    output ENABLE,
    input  IN,
    input  IN_VALID,
    input  PRESSED
  );

  // Slave is the encoder itself.
  modport slave (
    input  BTN,
    input  ENABLE,
    output IN,
    output IN_VALID,
    output PRESSED
  );
endinterface

// File: rtl/button_encoder.sv
// Synchronize, debounce and encode four player buttons into a 2-bit colour strobe.
// Latency: 2 + DB_CYCLES edges from the first sample of a stable press to IN_VALID.
// No backpressure: downstream must take IN in the single cycle IN_VALID is high.
module button_encoder #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  button_encoder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    REL_DB   = 3'd3,
    LOCK     = 3'd4
  } state_t;

  // Terminal count of a debounce window; DB_CYCLES may be as large as 2^CNT_W.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [3:0]       sync1;
  logic [3:0]       s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       cand, cand_nxt;
  logic             from_lock, from_lock_nxt;
  logic [1:0]       in_q, in_nxt;
  logic             vld_q, vld_nxt;
  logic             pressed_q, pressed_nxt;
  logic             s_one_hot;

  // Map a one-hot candidate to its colour index.
  function automatic logic [1:0] colour_of(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign s_one_hot = (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 4'd0;
      s     <= 4'd0;
    end else begin
      sync1 <= bus.BTN;
      s     <= sync1;
    end
  end

  // State, debounce counter, candidate and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 4'd0;
      from_lock <= 1'b0;
      in_q      <= 2'd0;
      vld_q     <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cand      <= cand_nxt;
      from_lock <= from_lock_nxt;
      in_q      <= in_nxt;
      vld_q     <= vld_nxt;
      pressed_q <= pressed_nxt;
    end
  end

  // Next-state and next-output decode; any state change restarts the counter.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cand_nxt      = cand;
    from_lock_nxt = from_lock;
    in_nxt        = in_q;
    vld_nxt       = 1'b0;
    pressed_nxt   = pressed_q;

    case (state)
      IDLE: begin
        if (s_one_hot) begin
          state_nxt = PRESS_DB;
          cand_nxt  = s;
        end else if (s != 4'd0) begin
          state_nxt = LOCK;
        end
      end
      PRESS_DB: begin
        if (s == 4'd0) begin
          state_nxt = IDLE;
        end else if (s != cand) begin
          state_nxt = LOCK;
        end else if (cnt == CNT_MAX) begin
          state_nxt   = HELD;
          in_nxt      = colour_of(cand);
          vld_nxt     = bus.ENABLE;
          pressed_nxt = bus.ENABLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (s == 4'd0) begin
          state_nxt     = REL_DB;
          from_lock_nxt = 1'b0;
        end
      end
      LOCK: begin
        if (s == 4'd0) begin
          state_nxt     = REL_DB;
          from_lock_nxt = 1'b1;
        end
      end
      REL_DB: begin
        if (s != 4'd0) begin
          state_nxt = from_lock ? LOCK : HELD;
        end else if (cnt == CNT_MAX) begin
          state_nxt   = IDLE;
          pressed_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (state_nxt != state) begin
      cnt_nxt = '0;
    end
  end

  assign bus.IN       = in_q;
  assign bus.IN_VALID = vld_q;
  assign bus.PRESSED  = pressed_q;

endmodule

// File: tb/tb_button_encoder.sv
// Directed scenarios plus randomized button traffic checked against a run-length reference model.
module tb_button_encoder;
  localparam int DB = 4;

  logic CLK;
  logic RST;
  button_encoder_if bif ();

  button_encoder #(.DB_CYCLES(DB), .CNT_W(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: synchronizer delay line plus run-length view of the synchronized samples.
  logic [3:0] m_s1, m_s2;
  logic [3:0] run_val;
  int         run_len;
  bit         busy;
  logic [1:0] exp_in;
  logic       exp_vld;
  logic       exp_pressed;

  // Scenario bookkeeping of what the DUT emitted.
  int         cyc, strobes, first_at, last_at, fall_at;
  logic [1:0] last_in;
  logic       prev_pressed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_s1 = 4'd0; m_s2 = 4'd0;
    run_val = 4'd0; run_len = 0; busy = 0;
    exp_in = 2'd0; exp_vld = 1'b0; exp_pressed = 1'b0;
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  // One rising edge of the reference: x is what the debouncer sees at this edge.
  task automatic m_edge(input logic [3:0] b, input logic en);
    logic [3:0] x, prev;
    if (RST) begin m_reset(); return; end
    x = m_s2; m_s2 = m_s1; m_s1 = b;
    prev = run_val;
    if (x == run_val) run_len++; else begin run_val = x; run_len = 1; end
    exp_vld = 1'b0;
    if (!busy) begin
      if ($countones(x) > 1) busy = 1;
      else if (x != 0 && prev != 0 && x != prev) busy = 1;
      else if ($countones(x) == 1 && run_len == DB + 1) begin
        busy = 1; exp_in = idx_of(x); exp_vld = en; exp_pressed = en;
      end
    end else if (x == 0 && run_len == DB + 1) begin
      busy = 0; exp_pressed = 1'b0;
    end
  endtask

  task automatic scn_begin();
    cyc = 0; strobes = 0; first_at = -1; last_at = -1; fall_at = -1;
  endtask

  // Drive at negedge, advance one edge, then check outputs at the following negedge.
  task automatic step(input logic [3:0] b, input logic en);
    bif.BTN = b; bif.ENABLE = en;
    prev_pressed = bif.PRESSED;
    @(posedge CLK);
    m_edge(b, en);
    @(negedge CLK);
    chk("IN", 32'(bif.IN), 32'(exp_in));
    chk("IN_VALID", 32'(bif.IN_VALID), 32'(exp_vld));
    chk("PRESSED", 32'(bif.PRESSED), 32'(exp_pressed));
    if (bif.IN_VALID === 1'b1) begin
      strobes++; last_in = bif.IN;
      if (first_at < 0) first_at = cyc;
      last_at = cyc;
    end
    if (prev_pressed === 1'b1 && bif.PRESSED === 1'b0) fall_at = cyc;
    cyc++;
  endtask

  task automatic hold(input logic [3:0] b, input logic en, input int n);
    for (int i = 0; i < n; i++) step(b, en);
  endtask

  initial begin
    logic [3:0] pat;
    int kind;
    RST = 1'b1; bif.BTN = 4'd0; bif.ENABLE = 1'b1; last_in = 2'd0; prev_pressed = 1'b0;
    m_reset();
    @(negedge CLK);
    chk("rst_IN", 32'(bif.IN), 32'd0);
    chk("rst_IN_VALID", 32'(bif.IN_VALID), 32'd0);
    chk("rst_PRESSED", 32'(bif.PRESSED), 32'd0);
    RST = 1'b0;
    hold(4'd0, 1'b1, 3);

    // Clean press of colour 2.
    scn_begin();
    hold(4'b0100, 1'b1, 20);
    hold(4'b0000, 1'b1, 10);
    chk("clean_strobes", 32'(strobes), 32'd1);
    chk("clean_in", 32'(last_in), 32'd2);
    chk("clean_strobe_edge", 32'(first_at), 32'(2 + DB));
    chk("clean_release_edge", 32'(fall_at), 32'(20 + 2 + DB));

    // Bouncy press of colour 1.
    scn_begin();
    for (int i = 0; i < 10; i++) step(((i / 2) % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1);
    hold(4'b0010, 1'b1, 15);
    hold(4'b0000, 1'b1, 10);
    chk("bounce_strobes", 32'(strobes), 32'd1);
    chk("bounce_in", 32'(last_in), 32'd1);
    chk("bounce_strobe_edge", 32'(first_at), 32'(8 + 2 + DB));

    // Chord is locked out until a full release.
    scn_begin();
    hold(4'b0011, 1'b1, 20);
    hold(4'b0010, 1'b1, 10);
    hold(4'b0000, 1'b1, 10);
    chk("chord_strobes", 32'(strobes), 32'd0);
    chk("chord_in_kept", 32'(bif.IN), 32'd1);
    hold(4'b1000, 1'b1, 10);
    hold(4'b0000, 1'b1, 10);
    chk("chord_next_strobes", 32'(strobes), 32'd1);
    chk("chord_next_in", 32'(last_in), 32'd3);

    // Repeat press with a release bounce.
    scn_begin();
    hold(4'b0001, 1'b1, 10);
    hold(4'b0000, 1'b1, 2);
    hold(4'b0001, 1'b1, 2);
    hold(4'b0000, 1'b1, 10);
    hold(4'b0001, 1'b1, 10);
    hold(4'b0000, 1'b1, 10);
    chk("repeat_strobes", 32'(strobes), 32'd2);
    chk("repeat_in", 32'(last_in), 32'd0);
    chk("repeat_gap_ok", 32'((last_at - first_at) >= 2 * DB + 3), 32'd1);

    // Disabled accept updates IN silently; late ENABLE does nothing.
    scn_begin();
    hold(4'b1000, 1'b0, 10);
    hold(4'b1000, 1'b1, 10);
    hold(4'b0000, 1'b1, 10);
    chk("disabled_strobes", 32'(strobes), 32'd0);
    chk("disabled_in", 32'(bif.IN), 32'd3);
    hold(4'b0100, 1'b1, 10);
    hold(4'b0000, 1'b1, 10);
    chk("enabled_after_strobes", 32'(strobes), 32'd1);
    chk("enabled_after_in", 32'(last_in), 32'd2);

    // Asynchronous reset in the middle of press debounce.
    scn_begin();
    hold(4'b0100, 1'b1, 3);
    #2 RST = 1'b1;
    m_reset();
    #1;
    chk("async_rst_IN", 32'(bif.IN), 32'd0);
    chk("async_rst_IN_VALID", 32'(bif.IN_VALID), 32'd0);
    chk("async_rst_PRESSED", 32'(bif.PRESSED), 32'd0);
    @(negedge CLK);
    hold(4'b0100, 1'b1, 2);
    RST = 1'b0;
    scn_begin();
    hold(4'b0100, 1'b1, 12);
    hold(4'b0000, 1'b1, 10);
    chk("post_rst_strobes", 32'(strobes), 32'd1);
    chk("post_rst_in", 32'(last_in), 32'd2);
    chk("post_rst_strobe_edge", 32'(first_at), 32'(2 + DB));

    // Randomized button traffic against the reference model.
    for (int p = 0; p < 80; p++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) pat = 4'd0;
      else if (kind == 1) pat = 4'b0001 << $urandom_range(0, 3);
      else pat = 4'($urandom_range(0, 15));
      hold(pat, ($urandom_range(0, 3) != 0), $urandom_range(1, 12));
    end
    hold(4'd0, 1'b1, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
